// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the MIPS general-purpose
//               register file (bus widths, enable levels, reset level).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  ReadEnable   = 1'b1;
   localparam logic                  ReadDisable  = 1'b0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
   localparam logic                  RstEnable    = 1'b0;

   // Destination triple delivered by the write-back path
   typedef struct packed {
      logic                  we;
      logic [RegAddrBus-1:0] waddr;
      logic [RegBus-1:0]     wdata;
   } wb_req_t;

   // A write-back only lands in storage when enabled and not aimed at $zero
   function automatic logic wb_commits(input wb_req_t req);
      return (req.we == WriteEnable) && (req.waddr != NOPRegAddr);
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
// Module      : regfile_rdport
// Description : Combinational read mux for one register-file read port.
//               Priority: reset, port disabled, $zero, write bypass, storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DW = RegBus,
   parameter int AW = RegAddrBus
) (
   input  logic          rst,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [DW-1:0] i_entry,
   output logic [DW-1:0] o_rdata
);

   // Select read data; bypass lets a same-cycle write-back reach decode
   always_comb begin
      o_rdata = '0;
      if (rst == RstEnable) begin
         o_rdata = '0;
      end else if (i_re == ReadDisable) begin
         o_rdata = '0;
      end else if (i_raddr == '0) begin
         o_rdata = '0;
      end else if ((i_we == WriteEnable) && (i_raddr == i_waddr)) begin
         o_rdata = i_wdata;
      end else begin
         o_rdata = i_entry;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : 32x32 MIPS general-purpose register file. Two combinational
//               read ports with write bypass, hardwired $zero, asynchronous
//               active-low clear and a registered debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
   import regfile_pkg::*;
#(
   parameter int DW   = RegBus,
   parameter int AW   = RegNumLog2,
   parameter int NREG = RegNum      // must equal 2**AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re1,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   input  logic          re2,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata2,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] r_mem [NREG];
   logic [DW-1:0] r_dbg_data;
   wb_req_t       w_wb;
   logic          w_commit;
   logic [DW-1:0] w_entry1;
   logic [DW-1:0] w_entry2;

   assign w_wb     = '{we: we, waddr: waddr, wdata: wdata};
   assign w_commit = wb_commits(w_wb);
   assign w_entry1 = r_mem[raddr1];
   assign w_entry2 = r_mem[raddr2];

   // Storage: cleared asynchronously; entry 0 is never written so stays zero
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= ZeroWord;
         end
      end else if (w_commit) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Debug port samples pre-write storage; no bypass on this path
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         r_dbg_data <= ZeroWord;
      end else begin
         r_dbg_data <= r_mem[dbg_addr];
      end
   end

   assign dbg_data = r_dbg_data;

   regfile_rdport #(.DW(DW), .AW(AW)) u_rdport1 (
      .rst     (rst),
      .i_re    (re1),
      .i_raddr (raddr1),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_entry (w_entry1),
      .o_rdata (rdata1)
   );

   regfile_rdport #(.DW(DW), .AW(AW)) u_rdport2 (
      .rst     (rst),
      .i_re    (re2),
      .i_raddr (raddr2),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_entry (w_entry2),
      .o_rdata (rdata2)
   );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module      : tb_regfile
// Description : Self-checking bench for regfile: directed scenarios plus
//               randomized traffic against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_checks;
   int n_fail;

   logic [31:0] mdl [32];

   regfile dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected read-port value from the architectural rules
   function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
      if (!rst)                   return 32'h0;
      if (!re)                    return 32'h0;
      if (ra == 5'd0)             return 32'h0;
      if (we && (ra == waddr))    return wdata;
      return mdl[ra];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2, input logic [4:0] da);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2; dbg_addr = da;
   endtask

   // One cycle: inputs already applied at negedge; check reads, then the edge
   task automatic cyc();
      logic [31:0] e_dbg;
      #1;
      chk("rdata1", rdata1, exp_rd(re1, raddr1));
      chk("rdata2", rdata2, exp_rd(re2, raddr2));
      @(posedge clk);
      if (!rst) begin
         clear_model();
         e_dbg = 32'h0;
      end else begin
         e_dbg = mdl[dbg_addr];
         if (we && waddr != 5'd0) mdl[waddr] = wdata;
      end
      #1;
      chk("dbg_data", dbg_data, e_dbg);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_model();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31, 5'd0);

      // Reset state
      @(negedge clk);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 5'(i));
         cyc();
      end

      // Write then read
      drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      cyc();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
      #1 chk("wr_rd", rdata1, 32'hDEADBEEF);
      #0 cyc();
      re1 = 1'b0;
      #1 chk("re1_off", rdata1, 32'h0);
      cyc();

      // Dual bypass then storage
      drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
      #1 chk("byp1", rdata1, 32'h12345678);
      chk("byp2", rdata2, 32'h12345678);
      cyc();
      we = 1'b0;
      #1 chk("stor1", rdata1, 32'h12345678);
      chk("stor2", rdata2, 32'h12345678);
      cyc();

      // $zero is immune to writes and bypass
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
      #1 chk("zero_byp", rdata1, 32'h0);
      cyc();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
      cyc();
      chk("zero_dbg", dbg_data, 32'h0);

      // Fill r1..r31 with their own address, then async reset mid-cycle
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(i), 1'b1, 5'(i), 1'b1, 5'(32 - i), 5'(i - 1));
         cyc();
      end
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd31, 5'd17);
      #1 chk("pre_arst", rdata1, 32'd17);
      #1 rst = 1'b0;
      #1 chk("arst_rdata1", rdata1, 32'h0);
      chk("arst_dbg", dbg_data, 32'h0);
      clear_model();
      #1 rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i ^ 5'h1F), 5'(i));
         cyc();
      end

      // Write during a full reset cycle is lost
      rst = 1'b0;
      drive(1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4);
      cyc();
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd4);
      #1 chk("lost_wr", rdata1, 32'h0);
      cyc();

      // Back-to-back writes to r9
      drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
      #1 chk("b2b_c0", rdata1, 32'hA);
      cyc();
      drive(1'b1, 5'd9, 32'hB, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
      #1 chk("b2b_c1", rdata1, 32'hB);
      cyc();
      chk("b2b_dbg1", dbg_data, 32'hA);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
      #1 chk("b2b_c2", rdata1, 32'hB);
      cyc();
      chk("b2b_dbg2", dbg_data, 32'hB);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(0, 31));
         rst = ($urandom_range(0, 59) != 0);
         drive(1'($urandom_range(0, 3) != 0), wa, $urandom,
               1'($urandom_range(0, 7) != 0),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 7) != 0),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         cyc();
      end
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
